// File: rtl/traffic_field_unit.sv
// traffic_field_unit: field-side companion of the intersection controller.
// Decodes the controller light codes into lamp drives (with a locally generated
// flash phase), debounces pedestrian buttons into held requests, drives the WALK
// lamps and latches a conflict fault that forces both heads to flashing yellow.
//
// Ports:
//   CLK, reset        clock, asynchronous active-high reset
//   L_A, L_B          3-bit light codes from the controller
//   RA, RB            controller "pedestrian served" indications
//   BTN_A, BTN_B      synchronised raw pedestrian buttons
//   CLR_FAULT         operator fault clear
//   LAMP_A, LAMP_B    lamp drives {R, Y, G, LARROW, RARROW}
//   WALK_A, WALK_B    walk lamps
//   PA, PB            held pedestrian requests to the controller
//   ERR               latched conflict fault
module traffic_field_unit #(
    parameter int unsigned DEB_CYC      = 4,
    parameter int unsigned FLASH_HALF   = 4,
    parameter int unsigned CONFLICT_CYC = 2
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic [2:0] L_A,
    input  logic [2:0] L_B,
    input  logic       RA,
    input  logic       RB,
    input  logic       BTN_A,
    input  logic       BTN_B,
    input  logic       CLR_FAULT,
    output logic [4:0] LAMP_A,
    output logic [4:0] LAMP_B,
    output logic       WALK_A,
    output logic       WALK_B,
    output logic       PA,
    output logic       PB,
    output logic       ERR
);

    localparam logic [7:0] DebLast   = 8'(DEB_CYC - 1);
    localparam logic [7:0] FlashLast = 8'(FLASH_HALF - 1);
    localparam logic [7:0] ConfLast  = 8'(CONFLICT_CYC - 1);

    localparam logic [4:0] LampR = 5'b10000;
    localparam logic [4:0] LampY = 5'b01000;

    function automatic logic is_green(input logic [2:0] code);
        return (code == 3'b110) || (code == 3'b101);
    endfunction

    function automatic logic [4:0] decode(input logic [2:0] code, input logic phase);
        logic [4:0] lamp;
        unique case (code)
            3'b110:  lamp = 5'b00100;
            3'b101:  lamp = 5'b00110;
            3'b100:  lamp = LampY;
            3'b011:  lamp = LampR;
            3'b010:  lamp = 5'b10001;
            3'b111:  lamp = phase ? LampR : 5'b00000;
            // 000 and the illegal 001 both show flashing yellow
            default: lamp = phase ? LampY : 5'b00000;
        endcase
        return lamp;
    endfunction

    // State
    logic [7:0]      flash_cnt_q, flash_cnt_d;
    logic            phase_q, phase_d;
    logic [7:0]      conf_cnt_q, conf_cnt_d;
    logic            err_d;
    logic [1:0][7:0] deb_cnt_q, deb_cnt_d;
    logic [1:0]      arm_q, arm_d;
    logic [1:0]      req_d;
    logic [4:0]      lamp_a_d, lamp_b_d;
    logic            walk_a_d, walk_b_d;

    logic       conflict;
    logic       err_clear;
    logic       flash_wrap;
    logic [1:0] btn, served, accept;

    assign btn    = {BTN_B, BTN_A};
    assign served = {RB, RA};

    always_comb begin
        flash_wrap  = (flash_cnt_q == FlashLast);
        flash_cnt_d = flash_wrap ? 8'd0 : flash_cnt_q + 8'd1;
        phase_d     = phase_q ^ flash_wrap;
    end

    // Conflict monitor. A clear is only honoured on a clean sample, and a clean
    // sample already zeroes the counter, so clearing ERR leaves the count at 0.
    always_comb begin
        conflict  = (L_A == 3'b001) || (L_B == 3'b001) || (is_green(L_A) && is_green(L_B));
        err_clear = ERR && CLR_FAULT && !conflict;
        if (!conflict || err_clear) begin
            conf_cnt_d = 8'd0;
        end else if (conf_cnt_q != 8'hff) begin
            conf_cnt_d = conf_cnt_q + 8'd1;
        end else begin
            conf_cnt_d = conf_cnt_q;
        end
        if (ERR) begin
            err_d = !err_clear;
        end else begin
            err_d = conflict && (conf_cnt_q >= ConfLast);
        end
    end

    // Button debounce and request handshake, index 0 = side A, 1 = side B.
    // arm drops on acceptance and returns only after a low sample, so a held
    // button yields exactly one request.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            accept[i] = btn[i] && arm_q[i] && (deb_cnt_q[i] >= DebLast);
            if (!btn[i]) begin
                deb_cnt_d[i] = 8'd0;
            end else if (deb_cnt_q[i] != 8'hff) begin
                deb_cnt_d[i] = deb_cnt_q[i] + 8'd1;
            end else begin
                deb_cnt_d[i] = deb_cnt_q[i];
            end
            arm_d[i] = !btn[i] ? 1'b1 : (accept[i] ? 1'b0 : arm_q[i]);
            if (ERR) begin
                req_d[i] = 1'b0;
            end else if (accept[i]) begin
                req_d[i] = 1'b1;  // new press wins over a same-edge release
            end else if (served[i]) begin
                req_d[i] = 1'b0;
            end else begin
                req_d[i] = (i == 0) ? PA : PB;
            end
        end
    end

    // Lamp and walk outputs; a latched fault overrides everything with flash yellow.
    always_comb begin
        if (ERR) begin
            lamp_a_d = phase_q ? LampY : 5'b00000;
            lamp_b_d = phase_q ? LampY : 5'b00000;
        end else begin
            lamp_a_d = decode(L_A, phase_q);
            lamp_b_d = decode(L_B, phase_q);
        end
        walk_a_d = RA && (L_A == 3'b111) && (L_B == 3'b111) && !ERR;
        walk_b_d = RB && (L_A == 3'b111) && (L_B == 3'b111) && !ERR;
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            flash_cnt_q <= 8'd0;
            phase_q     <= 1'b1;
            conf_cnt_q  <= 8'd0;
            deb_cnt_q   <= '0;
            arm_q       <= 2'b11;
            ERR         <= 1'b0;
            PA          <= 1'b0;
            PB          <= 1'b0;
            LAMP_A      <= 5'b00000;
            LAMP_B      <= 5'b00000;
            WALK_A      <= 1'b0;
            WALK_B      <= 1'b0;
        end else begin
            flash_cnt_q <= flash_cnt_d;
            phase_q     <= phase_d;
            conf_cnt_q  <= conf_cnt_d;
            deb_cnt_q   <= deb_cnt_d;
            arm_q       <= arm_d;
            ERR         <= err_d;
            PA          <= req_d[0];
            PB          <= req_d[1];
            LAMP_A      <= lamp_a_d;
            LAMP_B      <= lamp_b_d;
            WALK_A      <= walk_a_d;
            WALK_B      <= walk_b_d;
        end
    end

endmodule

// File: tb/tb_traffic_field_unit.sv
// Directed bench for traffic_field_unit (DEB_CYC = 4, FLASH_HALF = 4,
// CONFLICT_CYC = 2). A table covers flash, static decode and walk gating right
// after reset; hand sequences cover debounce, handshake, fault and async reset.
module tb_traffic_field_unit;

    logic       CLK = 1'b0;
    logic       reset;
    logic [2:0] L_A, L_B;
    logic       RA, RB, BTN_A, BTN_B, CLR_FAULT;
    logic [4:0] LAMP_A, LAMP_B;
    logic       WALK_A, WALK_B, PA, PB, ERR;

    traffic_field_unit #(
        .DEB_CYC     (4),
        .FLASH_HALF  (4),
        .CONFLICT_CYC(2)
    ) dut (
        .CLK      (CLK),
        .reset    (reset),
        .L_A      (L_A),
        .L_B      (L_B),
        .RA       (RA),
        .RB       (RB),
        .BTN_A    (BTN_A),
        .BTN_B    (BTN_B),
        .CLR_FAULT(CLR_FAULT),
        .LAMP_A   (LAMP_A),
        .LAMP_B   (LAMP_B),
        .WALK_A   (WALK_A),
        .WALK_B   (WALK_B),
        .PA       (PA),
        .PB       (PB),
        .ERR      (ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0] la;
        logic [2:0] lb;
        logic       ra;
        logic       rb;
        int         reps;
        logic [4:0] lamp_a;
        logic [4:0] lamp_b;
        logic       walk_a;
        logic       walk_b;
    } vec_t;

    int n_vec  = 0;
    int n_bad  = 0;
    int edge_n = 0;  // edges since the last reset release

    function automatic vec_t mk(input logic [2:0] la, input logic [2:0] lb, input logic ra,
                                input logic rb, input int reps, input logic [4:0] lamp_a,
                                input logic [4:0] lamp_b, input logic walk_a,
                                input logic walk_b);
        vec_t v;
        v.la = la; v.lb = lb; v.ra = ra; v.rb = rb; v.reps = reps;
        v.lamp_a = lamp_a; v.lamp_b = lamp_b; v.walk_a = walk_a; v.walk_b = walk_b;
        return v;
    endfunction

    function automatic logic [15:0] pk(input logic [4:0] la, input logic [4:0] lb,
                                       input logic wa, input logic wb, input logic pa,
                                       input logic pb, input logic er);
        return {1'b0, la, lb, wa, wb, pa, pb, er};
    endfunction

    function automatic logic [15:0] outs();
        return {1'b0, LAMP_A, LAMP_B, WALK_A, WALK_B, PA, PB, ERR};
    endfunction

    // Flash-yellow drive expected after edge edge_n: ON for edges 1-4, OFF 5-8, ...
    function automatic logic [4:0] flash_y();
        return ((((edge_n - 1) / 4) % 2) == 0) ? 5'b01000 : 5'b00000;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        edge_n++;
    endtask

    vec_t tbl[13];

    initial begin
        tbl[0]  = mk(3'b000, 3'b000, 0, 0, 4, 5'b01000, 5'b01000, 0, 0);
        tbl[1]  = mk(3'b000, 3'b000, 0, 0, 4, 5'b00000, 5'b00000, 0, 0);
        tbl[2]  = mk(3'b000, 3'b111, 0, 0, 4, 5'b01000, 5'b10000, 0, 0);
        tbl[3]  = mk(3'b111, 3'b000, 0, 0, 4, 5'b00000, 5'b00000, 0, 0);
        tbl[4]  = mk(3'b110, 3'b011, 0, 0, 3, 5'b00100, 5'b10000, 0, 0);
        tbl[5]  = mk(3'b101, 3'b011, 0, 0, 3, 5'b00110, 5'b10000, 0, 0);
        tbl[6]  = mk(3'b100, 3'b011, 0, 0, 3, 5'b01000, 5'b10000, 0, 0);
        tbl[7]  = mk(3'b011, 3'b110, 0, 0, 3, 5'b10000, 5'b00100, 0, 0);
        tbl[8]  = mk(3'b010, 3'b010, 0, 0, 3, 5'b10001, 5'b10001, 0, 0);
        tbl[9]  = mk(3'b111, 3'b011, 1, 0, 1, 5'b00000, 5'b10000, 0, 0);  // edge 32, phase off
        tbl[10] = mk(3'b111, 3'b111, 1, 0, 1, 5'b10000, 5'b10000, 1, 0);  // edge 33, phase on
        tbl[11] = mk(3'b111, 3'b111, 1, 1, 1, 5'b10000, 5'b10000, 1, 1);
        tbl[12] = mk(3'b011, 3'b011, 0, 0, 2, 5'b10000, 5'b10000, 0, 0);

        reset = 1'b1;
        L_A = 3'b000; L_B = 3'b000;
        RA = 0; RB = 0; BTN_A = 0; BTN_B = 0; CLR_FAULT = 0;
        #12;
        check("reset", outs(), 16'h0000);
        @(negedge CLK);
        reset  = 1'b0;
        edge_n = 0;

        for (int i = 0; i < 13; i++) begin
            L_A = tbl[i].la; L_B = tbl[i].lb; RA = tbl[i].ra; RB = tbl[i].rb;
            for (int r = 0; r < tbl[i].reps; r++) begin
                step();
                check($sformatf("vec%0d.%0d", i, r), outs(),
                      pk(tbl[i].lamp_a, tbl[i].lamp_b, tbl[i].walk_a, tbl[i].walk_b, 0, 0, 0));
            end
        end

        // Debounce: a 3-sample glitch is rejected, a 4-sample press is accepted.
        BTN_A = 1;
        for (int k = 1; k <= 3; k++) begin
            step();
            check($sformatf("deb_short%0d", k), {15'b0, PA}, 16'd0);
        end
        BTN_A = 0;
        step();
        check("deb_gap", {15'b0, PA}, 16'd0);
        BTN_A = 1;
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("deb_press%0d", k), {15'b0, PA}, {15'b0, k == 4});
        end
        repeat (20) step();
        check("deb_hold", {15'b0, PA}, 16'd1);
        RA = 1;
        step();
        check("ra_clear", {15'b0, PA}, 16'd0);
        RA = 0;
        repeat (5) step();
        check("no_rearm", {15'b0, PA}, 16'd0);
        BTN_A = 0;
        step();
        BTN_A = 1;
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("repress%0d", k), {15'b0, PA}, {15'b0, k == 4});
        end
        BTN_A = 0; RA = 1;
        step();
        check("ra_clear2", {15'b0, PA}, 16'd0);
        BTN_A = 1;  // RA stays high: acceptance on the 4th edge must win
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("same_edge%0d", k), {15'b0, PA}, {15'b0, k == 4});
        end
        RA = 0; BTN_A = 0;
        step();
        check("pa_held", {15'b0, PA}, 16'd1);
        BTN_B = 1;
        repeat (4) step();
        check("pb_set", {15'b0, PB}, 16'd1);
        BTN_B = 0; RB = 1;
        step();
        check("pb_clear", {15'b0, PB}, 16'd0);
        RB = 0;

        // Conflict monitor
        L_A = 3'b110; L_B = 3'b101;
        step();
        check("conf_one", {15'b0, ERR}, 16'd0);
        L_A = 3'b011; L_B = 3'b011;
        step();
        check("conf_gap", {15'b0, ERR}, 16'd0);
        L_A = 3'b110; L_B = 3'b101;
        step();
        check("conf_first", {15'b0, ERR}, 16'd0);
        step();
        check("conf_set", {15'b0, ERR}, 16'd1);
        step();
        check("err_override", outs(), pk(flash_y(), flash_y(), 0, 0, 0, 0, 1));
        CLR_FAULT = 1;
        step();
        check("clr_ignored", {15'b0, ERR}, 16'd1);
        CLR_FAULT = 0; L_A = 3'b011; L_B = 3'b011;
        step();
        check("err_sticky", outs(), pk(flash_y(), flash_y(), 0, 0, 0, 0, 1));
        CLR_FAULT = 1;
        step();
        check("err_clear", {15'b0, ERR}, 16'd0);
        CLR_FAULT = 0;
        step();
        check("post_clear", outs(), pk(5'b10000, 5'b10000, 0, 0, 0, 0, 0));

        // Illegal code faults too; WALK is suppressed under the fault.
        L_A = 3'b001; L_B = 3'b111; RA = 1;
        step();
        check("illegal_first", {15'b0, ERR}, 16'd0);
        step();
        check("illegal_set", {15'b0, ERR}, 16'd1);
        step();
        check("err_walk", outs(), pk(flash_y(), flash_y(), 0, 0, 0, 0, 1));

        // Asynchronous reset between edges
        #2 reset = 1'b1;
        #1;
        check("async_rst", outs(), 16'h0000);
        L_A = 3'b011; L_B = 3'b011; RA = 0;
        @(negedge CLK);
        reset  = 1'b0;
        edge_n = 0;
        step();
        check("after_rst", outs(), pk(5'b10000, 5'b10000, 0, 0, 0, 0, 0));
        L_A = 3'b000; L_B = 3'b000;
        step();
        check("after_rst_flash", outs(), pk(5'b01000, 5'b01000, 0, 0, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/traffic_field_unit.md
# traffic_field_unit

Field-side counterpart of the intersection traffic controller. It sits between the controller and the physical signal heads and push-buttons:
- decodes the controller's 3-bit light codes L_A/L_B into individual lamp drives, including locally generated flashing;
- debounces pedestrian buttons into held PA/PB requests, released by the controller's RA/RB;
- drives WALK lamps;
- runs a conflict monitor that raises ERR back into the controller.

## Interface
Parameters:
- DEB_CYC, 4: consecutive high samples needed to accept a button press (1..255).
- FLASH_HALF, 4: cycles per flash half-period (1..255).
- CONFLICT_CYC, 2: consecutive conflicting samples before ERR latches (1..255).

Ports (one clock; reset is asynchronous, active-high):
- CLK  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- L_A, L_B  input  3  light codes from controller: 110 GREEN, 101 G_LEFT, 100 YELLOW, 011 RED, 010 G_RIGHT, 111 FLASH_RED, 000 FLASH_YELLOW, 001 illegal.
- RA, RB  input  1  controller pedestrian-served indications.
- BTN_A, BTN_B  input  1  raw (pre-synchronised) pedestrian buttons.
- CLR_FAULT  input  1  operator fault clear.
- LAMP_A, LAMP_B  output  5  lamp drives {R, Y, G, LARROW, RARROW}, bit4 = R.
- WALK_A, WALK_B  output  1  walk lamps.
- PA, PB  output  1  pedestrian requests to controller.
- ERR  output  1  latched conflict fault to controller.

## Operation
Reset values:
- LAMP_A = LAMP_B = 00000.
- WALK_*, PA, PB and ERR = 0.
- Flash phase = ON; all counters = 0; button arm flags = 1.

Lamp decode (registered, from the sampled code):
- GREEN → G
- G_LEFT → G + LARROW
- YELLOW → Y
- RED → R
- G_RIGHT → R + RARROW
- FLASH_RED → R while phase ON, else 0
- FLASH_YELLOW → Y while phase ON, else 0
- 001 → Y gated by phase (treated as flash yellow)

Flash generator:
- Counter 0..FLASH_HALF-1 runs freely; phase toggles on the edge where the counter wraps.
- A single phase drives both heads, so both heads always flash in step.

Fault override:
- While ERR = 1, both heads show Y gated by phase, WALK_* = 0 and PA/PB are held 0, regardless of L_A/L_B/RA/RB.

Walk:
- WALK_A <= RA && L_A == 111 && L_B == 111 && !ERR. WALK_B is the same with RB.
- WALK is not gated by the flash phase.

Button/request path, per side (shown for A):
- Debounce counter increments while BTN_A is sampled 1 and clears on any 0 sample.
- A press is accepted on the edge where BTN_A has been 1 for DEB_CYC consecutive samples and arm = 1. That edge sets PA = 1 and arm = 0.
- arm returns to 1 after one sampled BTN_A = 0. Holding the button never produces a second request.
- PA clears on the edge after RA is sampled 1.
- If RA = 1 and a press is accepted on the same edge, PA stays 1 (the new request wins).

Conflict monitor:
- A sample is conflicting when either code is 001, or both codes are in {GREEN, G_LEFT}.
- The counter increments on conflicting samples and clears on clean ones.
- ERR sets on the edge completing CONFLICT_CYC consecutive conflicting samples, and stays set.
- ERR clears only on an edge where CLR_FAULT = 1 and the current sample is clean. CLR_FAULT during a conflict is ignored.
- Clearing ERR also zeroes the conflict counter.

## Timing
- Every output is a flop. Lamp and WALK latency is 1 cycle from L_*/RA/RB.
- PA latency is DEB_CYC edges from the first high button sample.
- ERR latency is CONFLICT_CYC edges from the first conflicting sample.
- Reset asserted mid-operation forces the reset values immediately (asynchronously); on release, operation resumes from reset state on the next edge.
- Priority on any edge: reset > ERR override > normal decode.

## Test plan
- Reset and flash: reset, then hold L_A = L_B = 000 with FLASH_HALF = 4 → LAMP_* alternate 01000 for 4 cycles and 00000 for 4 cycles, in step on both heads.
- Static decode: drive each legal code on L_A for 3 cycles → LAMP_A matches the decode one cycle later (110 → 00100, 101 → 00110, 010 → 10001, 011 → 10000).
- Debounce and handshake: BTN_A high for 3 cycles, low, then high for 4 cycles → PA rises only after the 4th high sample. Hold the button 20 more cycles and pulse RA = 1 → PA falls the next edge and does not re-assert until release and a new 4-sample press.
- Walk gating: RA = 1 with L_A = 111 and L_B = 011 → WALK_A = 0. Then set L_B = 111 → WALK_A = 1 one cycle later.
- Conflict: L_A = 110, L_B = 101 for 1 cycle then clean → ERR stays 0. Hold the conflict for 2 cycles → ERR = 1, and heads flash yellow with PA/PB = 0. CLR_FAULT during the conflict → no effect. CLR_FAULT after the conflict clears → ERR = 0 next edge.
- Async reset mid-press: assert reset between edges while PA = 1 and ERR = 1 → all outputs 0 before the next clock edge.
